// File: rtl/getir_birimi_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the conditional-branch opcode and the default reset PC.
// Latency: n/a (definitions only). Backpressure: n/a.
package getir_birimi_pkg;

   // Fetch FSM states, 2-bit encoded.
   typedef enum logic [1:0] {
      ISTE  = 2'b00,   // issue one memory request
      BEKLE = 2'b01,   // wait for the response
      SUN   = 2'b10,   // present the instruction to decode
      IPTAL = 2'b11    // drain a response made stale by a redirect
   } durum_t;

   localparam logic [6:0]  DALLANMA_OPKODU         = 7'b1100011;
   localparam logic [31:0] VARSAYILAN_BASLANGIC_PS = 32'h0000_0000;

   function automatic logic dallanma_mi(input logic [6:0] opkod);
      return (opkod == DALLANMA_OPKODU);
   endfunction

endpackage

// File: rtl/getir_birimi_sonraki_ps.sv
// Next-PC selector: predicted target for a conditional branch the predictor
// marks taken, otherwise ps+4 (wraps modulo 2^32). Purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Ports: ps, opkod (instruction[6:0]), sonuc_dallan, sonuc_dallan_ps in;
//        sonraki_ps, tahmin out.
module sonraki_ps_secici
   import getir_birimi_pkg::*;
(
   input  logic [31:0] ps,
   input  logic [6:0]  opkod,
   input  logic        sonuc_dallan,
   input  logic [31:0] sonuc_dallan_ps,
   output logic [31:0] sonraki_ps,
   output logic        tahmin
);

   always_comb begin
      tahmin     = sonuc_dallan & dallanma_mi(opkod);
      sonraki_ps = tahmin ? sonuc_dallan_ps : (ps + 32'd4);
   end

endmodule

// File: rtl/getir_birimi.sv
// Instruction fetch unit: issues one word request at ps, waits for the reply,
// presents it to decode and advances ps (sequential or predicted target).
// Latency: request at n, presented at n+2 with 1-cycle memory; 1 instr / 3 cycles peak.
// Backpressure: holds the presented instruction until coz_hazir; duzelt overrides all.
// Ports: clk, rst; bellek_istek/adres out, bellek_hazir/veri in;
//        getir_ps/buyruk/gecerli, cikis_tahmin out; sonuc_dallan(_ps), coz_hazir,
//        duzelt(_ps) in.
module getir_birimi
   import getir_birimi_pkg::*;
#(
   parameter logic [31:0] BASLANGIC_PS = VARSAYILAN_BASLANGIC_PS
) (
   input  logic        clk,
   input  logic        rst,
   output logic        bellek_istek,
   output logic [31:0] bellek_adres,
   input  logic        bellek_hazir,
   input  logic [31:0] bellek_veri,
   output logic [31:0] getir_ps,
   output logic [31:0] getir_buyruk,
   output logic        getir_gecerli,
   input  logic        sonuc_dallan,
   input  logic [31:0] sonuc_dallan_ps,
   input  logic        coz_hazir,
   output logic        cikis_tahmin,
   input  logic        duzelt,
   input  logic [31:0] duzelt_ps
);

   durum_t      durum_q, durum_d;
   logic [31:0] ps_q, ps_d;
   logic [31:0] buyruk_q, buyruk_d;
   logic [31:0] sonraki_ps;
   logic        tahmin;

   sonraki_ps_secici u_sonraki_ps (
      .ps              (ps_q),
      .opkod           (buyruk_q[6:0]),
      .sonuc_dallan    (sonuc_dallan),
      .sonuc_dallan_ps (sonuc_dallan_ps),
      .sonraki_ps      (sonraki_ps),
      .tahmin          (tahmin)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         durum_q  <= ISTE;
         ps_q     <= BASLANGIC_PS;
         buyruk_q <= '0;
      end else begin
         durum_q  <= durum_d;
         ps_q     <= ps_d;
         buyruk_q <= buyruk_d;
      end
   end

   always_comb begin
      durum_d  = durum_q;
      ps_d     = ps_q;
      buyruk_d = buyruk_q;
      if (duzelt) begin
         // Redirect wins over everything; the low two bits are not part of a
         // word address.
         ps_d = duzelt_ps & 32'hFFFF_FFFC;
         case (durum_q)
            // A request is in flight: if its reply lands this very cycle it is
            // simply dropped, otherwise it must be drained in IPTAL so that only
            // one request is ever outstanding.
            BEKLE, IPTAL: durum_d = bellek_hazir ? ISTE : IPTAL;
            default:      durum_d = ISTE;
         endcase
      end else begin
         case (durum_q)
            ISTE:  durum_d = BEKLE;
            BEKLE: begin
               if (bellek_hazir) begin
                  buyruk_d = bellek_veri;
                  durum_d  = SUN;
               end
            end
            SUN: begin
               if (coz_hazir) begin
                  ps_d    = sonraki_ps;
                  durum_d = ISTE;
               end
            end
            IPTAL: begin
               if (bellek_hazir) durum_d = ISTE;
            end
            default: durum_d = ISTE;
         endcase
      end
   end

   // No request while reset is held or while a redirect is being taken: the
   // request must go out at the new PC in the following cycle.
   assign bellek_istek  = (durum_q == ISTE) & ~rst & ~duzelt;
   assign bellek_adres  = ps_q;
   assign getir_ps      = ps_q;
   assign getir_buyruk  = buyruk_q;
   assign getir_gecerli = (durum_q == SUN);
   assign cikis_tahmin  = tahmin;

endmodule

// File: tb/tb_getir_birimi.sv
module tb_getir_birimi;

   logic        clk = 1'b0;
   logic        rst;
   logic        bellek_istek;
   logic [31:0] bellek_adres;
   logic        bellek_hazir;
   logic [31:0] bellek_veri;
   logic [31:0] getir_ps;
   logic [31:0] getir_buyruk;
   logic        getir_gecerli;
   logic        sonuc_dallan;
   logic [31:0] sonuc_dallan_ps;
   logic        coz_hazir;
   logic        cikis_tahmin;
   logic        duzelt;
   logic [31:0] duzelt_ps;

   int toplam = 0;
   int hata   = 0;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] DAL    = 32'hFE00_0EE3;
   localparam logic [31:0] COP    = 32'hDEAD_BEEF;

   getir_birimi #(.BASLANGIC_PS(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .bellek_istek    (bellek_istek),
      .bellek_adres    (bellek_adres),
      .bellek_hazir    (bellek_hazir),
      .bellek_veri     (bellek_veri),
      .getir_ps        (getir_ps),
      .getir_buyruk    (getir_buyruk),
      .getir_gecerli   (getir_gecerli),
      .sonuc_dallan    (sonuc_dallan),
      .sonuc_dallan_ps (sonuc_dallan_ps),
      .coz_hazir       (coz_hazir),
      .cikis_tahmin    (cikis_tahmin),
      .duzelt          (duzelt),
      .duzelt_ps       (duzelt_ps)
   );

   always #5 clk = ~clk;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      toplam++;
      assert (gozlenen === beklenen) else begin
         hata++;
         $error("FAIL %s: observed=%h expected=%h", etiket, gozlenen, beklenen);
      end
   endtask

   // Advance one cycle: inputs change and outputs are sampled after negedge.
   task automatic tik();
      @(negedge clk);
   endtask

   // One fetch: expects a request at 'adres' this cycle, answers after
   // 'gecikme' cycles with 'veri', and checks the presented instruction.
   // Any bellek_hazir the caller set for the request cycle is cleared after it.
   task automatic getir(input logic [31:0] adres, input logic [31:0] veri,
                        input int gecikme);
      #1;
      kontrol("istek", {31'd0, bellek_istek}, 32'd1);
      kontrol("adres", bellek_adres, adres);
      kontrol("gecerli_iste", {31'd0, getir_gecerli}, 32'd0);
      tik();
      bellek_hazir = 1'b0;
      for (int i = 1; i < gecikme; i++) begin
         #1;
         kontrol("istek_bekle", {31'd0, bellek_istek}, 32'd0);
         kontrol("gecerli_bekle", {31'd0, getir_gecerli}, 32'd0);
         tik();
      end
      bellek_hazir = 1'b1;
      bellek_veri  = veri;
      #1;
      kontrol("istek_yanit", {31'd0, bellek_istek}, 32'd0);
      tik();
      bellek_hazir = 1'b0;
      bellek_veri  = 32'h0;
      #1;
      kontrol("gecerli_sun", {31'd0, getir_gecerli}, 32'd1);
      kontrol("buyruk_sun", getir_buyruk, veri);
      kontrol("ps_sun", getir_ps, adres);
   endtask

   // Decode accepts the presented instruction with the given prediction.
   task automatic kabul(input logic dallan, input logic [31:0] hedef,
                        input logic bek_tahmin);
      coz_hazir       = 1'b1;
      sonuc_dallan    = dallan;
      sonuc_dallan_ps = hedef;
      #1;
      kontrol("tahmin", {31'd0, cikis_tahmin}, {31'd0, bek_tahmin});
      tik();
      coz_hazir       = 1'b0;
      sonuc_dallan    = 1'b0;
      sonuc_dallan_ps = 32'h0;
   endtask

   initial begin
      rst = 1'b1; bellek_hazir = 1'b0; bellek_veri = 32'h0;
      sonuc_dallan = 1'b0; sonuc_dallan_ps = 32'h0; coz_hazir = 1'b0;
      duzelt = 1'b0; duzelt_ps = 32'h0;

      // Reset state
      tik(); tik();
      #1;
      kontrol("rst_istek", {31'd0, bellek_istek}, 32'd0);
      kontrol("rst_gecerli", {31'd0, getir_gecerli}, 32'd0);
      kontrol("rst_buyruk", getir_buyruk, 32'h0);
      kontrol("rst_tahmin", {31'd0, cikis_tahmin}, 32'd0);
      kontrol("rst_ps", getir_ps, 32'h0);

      // First cycle after reset: request at 0, a stray reply is ignored
      rst = 1'b0;
      bellek_hazir = 1'b1; bellek_veri = COP;
      getir(32'h0, NOP, 1);
      kabul(1'b0, 32'h0, 1'b0);
      getir(32'h4, ADDI, 1);
      kabul(1'b0, 32'h0, 1'b0);
      getir(32'h8, NOP, 1);
      kabul(1'b0, 32'h0, 1'b0);
      // Non-branch with predictor saying taken: no prediction, ps+4
      getir(32'hC, NOP, 1);
      kabul(1'b1, 32'h40, 1'b0);

      // Branch taken to 0x0C, then not taken -> 0x14
      getir(32'h10, DAL, 1);
      kabul(1'b1, 32'hC, 1'b1);
      getir(32'hC, NOP, 1);
      kabul(1'b0, 32'h0, 1'b0);
      getir(32'h10, DAL, 1);
      kabul(1'b0, 32'hC, 1'b0);

      // Decode stall for 5 cycles
      getir(32'h14, ADDI, 1);
      for (int i = 0; i < 5; i++) begin
         tik(); #1;
         kontrol("stall_gecerli", {31'd0, getir_gecerli}, 32'd1);
         kontrol("stall_buyruk", getir_buyruk, ADDI);
         kontrol("stall_ps", getir_ps, 32'h14);
         kontrol("stall_istek", {31'd0, bellek_istek}, 32'd0);
      end
      tik();
      kabul(1'b0, 32'h0, 1'b0);
      getir(32'h18, NOP, 2);
      kabul(1'b0, 32'h0, 1'b0);

      // Redirect while waiting (latency 3): stale reply drained, never shown
      #1;
      kontrol("iptal_istek", {31'd0, bellek_istek}, 32'd1);
      kontrol("iptal_adres", bellek_adres, 32'h1C);
      tik();
      duzelt = 1'b1; duzelt_ps = 32'h103;
      #1;
      kontrol("iptal_istek1", {31'd0, bellek_istek}, 32'd0);
      tik();
      duzelt = 1'b0; duzelt_ps = 32'h0;
      #1;
      kontrol("iptal_istek2", {31'd0, bellek_istek}, 32'd0);
      kontrol("iptal_gecerli2", {31'd0, getir_gecerli}, 32'd0);
      tik();
      bellek_hazir = 1'b1; bellek_veri = COP;
      #1;
      kontrol("iptal_istek3", {31'd0, bellek_istek}, 32'd0);
      kontrol("iptal_gecerli3", {31'd0, getir_gecerli}, 32'd0);
      tik();
      bellek_hazir = 1'b0; bellek_veri = 32'h0;
      getir(32'h100, NOP, 1);
      kabul(1'b0, 32'h0, 1'b0);

      // Redirect in the same cycle as the reply: reply dropped
      #1;
      kontrol("es_adres", bellek_adres, 32'h104);
      tik();
      bellek_hazir = 1'b1; bellek_veri = COP;
      duzelt = 1'b1; duzelt_ps = 32'h300;
      tik();
      bellek_hazir = 1'b0; duzelt = 1'b0; duzelt_ps = 32'h0;
      getir(32'h300, DAL, 1);

      // Redirect together with the handshake on a predicted-taken branch
      duzelt = 1'b1; duzelt_ps = 32'h200;
      kabul(1'b1, 32'h40, 1'b1);
      duzelt = 1'b0; duzelt_ps = 32'h0;

      // Reset while waiting: stale reply in first cycle after reset ignored
      #1;
      kontrol("rb_adres", bellek_adres, 32'h200);
      tik();
      rst = 1'b1;
      #1;
      kontrol("rb_istek", {31'd0, bellek_istek}, 32'd0);
      tik();
      rst = 1'b0;
      #1;
      kontrol("rb_gecerli", {31'd0, getir_gecerli}, 32'd0);
      kontrol("rb_ps", getir_ps, 32'h0);
      bellek_hazir = 1'b1; bellek_veri = COP;
      getir(32'h0, ADDI, 1);

      // Redirect to an unaligned top address, then wrap to 0
      duzelt = 1'b1; duzelt_ps = 32'hFFFF_FFFF;
      tik();
      duzelt = 1'b0; duzelt_ps = 32'h0;
      #1;
      kontrol("duz_gecerli", {31'd0, getir_gecerli}, 32'd0);
      getir(32'hFFFF_FFFC, NOP, 1);
      kabul(1'b0, 32'h0, 1'b0);
      getir(32'h0, NOP, 1);

      $display("test done: total=%0d bad=%0d", toplam, hata);
      $finish;
   end

endmodule
